// File: rtl/dmem_arbiter.sv
// Two-requester round-robin arbiter in front of a single-port data BRAM.
// Requester A is the core data port, requester B the DMA/debug loader.
// One access is granted per cycle; read data returns one cycle after the
// grant on the port of the requester that issued the read.
module dmem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int BE_W   = DATA_W / 8
) (
  input  logic              clk,
  input  logic              reset,

  input  logic              a_req,
  input  logic [BE_W-1:0]   a_we,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_wdata,
  output logic              a_gnt,
  output logic              a_rvalid,
  output logic [DATA_W-1:0] a_rdata,

  input  logic              b_req,
  input  logic [BE_W-1:0]   b_we,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_wdata,
  output logic              b_gnt,
  output logic              b_rvalid,
  output logic [DATA_W-1:0] b_rdata,

  output logic              mem_en,
  output logic [BE_W-1:0]   mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic {
    REQ_A = 1'b0,
    REQ_B = 1'b1
  } req_e;

  req_e r_last;
  req_e r_rd_owner;
  logic r_rd_pend;

  logic w_gnt_a;
  logic w_gnt_b;
  logic w_rd;

  // Round-robin grant: a tie goes to the requester not granted last; nothing while in reset
  always_comb begin
    w_gnt_a = 1'b0;
    w_gnt_b = 1'b0;
    if (!reset) begin
      if (a_req && b_req) begin
        if (r_last == REQ_B) begin
          w_gnt_a = 1'b1;
        end else begin
          w_gnt_b = 1'b1;
        end
      end else begin
        w_gnt_a = a_req;
        w_gnt_b = b_req;
      end
    end
  end

  // Steer the granted requester onto the BRAM port; zeros when idle
  always_comb begin
    mem_en    = 1'b0;
    mem_we    = '0;
    mem_addr  = '0;
    mem_wdata = '0;
    w_rd      = 1'b0;
    if (w_gnt_a) begin
      mem_en    = 1'b1;
      mem_we    = a_we;
      mem_addr  = a_addr;
      mem_wdata = a_wdata;
      w_rd      = (a_we == '0);
    end else if (w_gnt_b) begin
      mem_en    = 1'b1;
      mem_we    = b_we;
      mem_addr  = b_addr;
      mem_wdata = b_wdata;
      w_rd      = (b_we == '0);
    end
  end

  // Priority pointer and one-deep read-return tracking
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_last     <= REQ_B;
      r_rd_pend  <= 1'b0;
      r_rd_owner <= REQ_A;
    end else begin
      if (w_gnt_a) begin
        r_last <= REQ_A;
      end else if (w_gnt_b) begin
        r_last <= REQ_B;
      end
      r_rd_pend  <= w_rd;
      r_rd_owner <= w_gnt_b ? REQ_B : REQ_A;
    end
  end

  // Route returning read data to its owner only; rdata is zero whenever rvalid is low
  always_comb begin
    a_gnt    = w_gnt_a;
    b_gnt    = w_gnt_b;
    a_rvalid = r_rd_pend && !reset && (r_rd_owner == REQ_A);
    b_rvalid = r_rd_pend && !reset && (r_rd_owner == REQ_B);
    a_rdata  = a_rvalid ? mem_rdata : '0;
    b_rdata  = b_rvalid ? mem_rdata : '0;
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: a behavioural BRAM behind the arbiter, a
// transaction-level reference model checked every cycle, directed scenarios
// and a randomized tail.
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        a_req, b_req;
  logic [3:0]  a_we, b_we;
  logic [31:0] a_addr, b_addr, a_wdata, b_wdata;
  logic        a_gnt, b_gnt, a_rvalid, b_rvalid;
  logic [31:0] a_rdata, b_rdata;
  logic        mem_en;
  logic [3:0]  mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [31:0] mem_rdata;

  int checks = 0;
  int errors = 0;

  dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .BE_W(4)) dut (
    .clk(clk), .reset(reset),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Behavioural BRAM: 16 words, 1-cycle synchronous read, byte write enables
  logic [31:0] bram [0:15];
  initial begin
    for (int i = 0; i < 16; i++) bram[i] = '0;
    mem_rdata = '0;
  end
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we != 4'd0) begin
        for (int i = 0; i < 4; i++)
          if (mem_we[i]) bram[mem_addr[5:2]][8*i +: 8] <= mem_wdata[8*i +: 8];
      end else begin
        mem_rdata <= bram[mem_addr[5:2]];
      end
    end
  end

  // Reference model state (transaction level)
  logic [31:0] shadow [0:15];
  int          m_last  = 1;     // 0 = A granted last, 1 = B
  bit          m_pend  = 0;
  int          m_owner = 0;
  logic [31:0] m_data  = '0;

  // Snapshots of the last sampled cycle for directed checks
  logic        s_agnt, s_bgnt, s_arv, s_brv;
  logic [31:0] s_ard, s_brd;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic set_a(input logic req, input logic [3:0] we, input logic [31:0] addr, input logic [31:0] wd);
    a_req = req; a_we = we; a_addr = addr; a_wdata = wd;
  endtask

  task automatic set_b(input logic req, input logic [3:0] we, input logic [31:0] addr, input logic [31:0] wd);
    b_req = req; b_we = we; b_addr = addr; b_wdata = wd;
  endtask

  // One clock cycle: check all outputs against the model mid-cycle, then advance the model
  task automatic step();
    bit          ea, eb, granted, rd, av, bv;
    logic [3:0]  ewe;
    logic [31:0] eaddr, ewd;
    @(negedge clk);
    ea = 0; eb = 0;
    if (!reset) begin
      if (a_req && b_req) begin
        ea = (m_last == 1);
        eb = !ea;
      end else begin
        ea = a_req;
        eb = b_req;
      end
    end
    granted = ea || eb;
    ewe   = ea ? a_we    : (eb ? b_we    : 4'd0);
    eaddr = ea ? a_addr  : (eb ? b_addr  : 32'd0);
    ewd   = ea ? a_wdata : (eb ? b_wdata : 32'd0);
    av = m_pend && !reset && (m_owner == 0);
    bv = m_pend && !reset && (m_owner == 1);

    chk("a_gnt", a_gnt, ea);
    chk("b_gnt", b_gnt, eb);
    chk("mem_en", mem_en, granted);
    chk("mem_we", mem_we, ewe);
    chk("mem_addr", mem_addr, eaddr);
    chk("mem_wdata", mem_wdata, ewd);
    chk("a_rvalid", a_rvalid, av);
    chk("a_rdata", a_rdata, av ? m_data : 32'd0);
    chk("b_rvalid", b_rvalid, bv);
    chk("b_rdata", b_rdata, bv ? m_data : 32'd0);

    s_agnt = a_gnt; s_bgnt = b_gnt;
    s_arv = a_rvalid; s_ard = a_rdata;
    s_brv = b_rvalid; s_brd = b_rdata;

    if (reset) begin
      m_last = 1;
      m_pend = 0;
    end else begin
      if (granted) m_last = eb ? 1 : 0;
      rd = granted && (ewe == 4'd0);
      if (rd) begin
        m_owner = eb ? 1 : 0;
        m_data  = shadow[eaddr[5:2]];
      end
      m_pend = rd;
      if (granted && ewe != 4'd0)
        for (int i = 0; i < 4; i++)
          if (ewe[i]) shadow[eaddr[5:2]][8*i +: 8] = ewd[8*i +: 8];
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 16; i++) shadow[i] = '0;
    reset = 1'b1;
    set_a(1, 4'h0, 32'h0, 32'h0);
    set_b(1, 4'h0, 32'h4, 32'h0);

    // Reset held with both requesting
    step();
    chk("rst_a_gnt", s_agnt, 0);
    chk("rst_b_gnt", s_bgnt, 0);
    chk("rst_a_rvalid", s_arv, 0);
    step();

    // Release with both requesting: A then B
    reset = 1'b0;
    step();
    chk("rel_first_a", s_agnt, 1);
    step();
    chk("rel_second_b", s_bgnt, 1);
    set_a(0, 4'h0, 32'h0, 32'h0);
    set_b(0, 4'h0, 32'h0, 32'h0);
    step();

    // Preload via B
    set_b(1, 4'hF, 32'h10, 32'h11111111);
    step();
    set_b(1, 4'hF, 32'h20, 32'h22222222);
    step();

    // Contention: both hold reads for 6 cycles
    set_a(1, 4'h0, 32'h10, 32'h0);
    set_b(1, 4'h0, 32'h20, 32'h0);
    for (int i = 0; i < 6; i++) begin
      step();
      chk("cont_a_gnt", s_agnt, (i % 2) == 0);
      chk("cont_b_gnt", s_bgnt, (i % 2) == 1);
      if (i > 0) begin
        chk("cont_a_rvalid", s_arv, (i % 2) == 1);
        chk("cont_b_rvalid", s_brv, (i % 2) == 0);
        chk("cont_rdata", (i % 2) ? s_ard : s_brd, (i % 2) ? 32'h11111111 : 32'h22222222);
      end
    end
    set_a(0, 4'h0, 32'h0, 32'h0);
    set_b(0, 4'h0, 32'h0, 32'h0);
    step();
    chk("cont_last_b", s_brd, 32'h22222222);

    // A write then read
    set_a(1, 4'hF, 32'h10, 32'hDEADBEEF);
    step();
    chk("a_wr_gnt", s_agnt, 1);
    set_a(1, 4'h0, 32'h10, 32'h0);
    step();
    chk("a_rd_gnt", s_agnt, 1);
    chk("a_rd_no_early", s_arv, 0);
    set_a(0, 4'h0, 32'h0, 32'h0);
    step();
    chk("a_rd_rvalid", s_arv, 1);
    chk("a_rd_data", s_ard, 32'hDEADBEEF);
    chk("a_rd_b_quiet", s_brv, 0);

    // Byte write by B, read back by A
    set_b(1, 4'b0100, 32'h10, 32'h00AB0000);
    step();
    set_b(0, 4'h0, 32'h0, 32'h0);
    set_a(1, 4'h0, 32'h10, 32'h0);
    step();
    set_a(0, 4'h0, 32'h0, 32'h0);
    step();
    chk("byte_merge", s_ard, 32'hDEABBEEF);

    // Reset right after a granted read
    set_a(1, 4'h0, 32'h20, 32'h0);
    step();
    chk("mid_rd_gnt", s_agnt, 1);
    reset = 1'b1;
    set_a(1, 4'h0, 32'h10, 32'h0);
    set_b(1, 4'h0, 32'h20, 32'h0);
    step();
    chk("mid_rst_no_rvalid", s_arv, 0);
    reset = 1'b0;
    step();
    chk("mid_rel_a_first", s_agnt, 1);
    chk("mid_rel_no_replay", s_arv, 0);
    step();
    chk("mid_rel_b_next", s_bgnt, 1);
    set_a(0, 4'h0, 32'h0, 32'h0);
    set_b(0, 4'h0, 32'h0, 32'h0);
    step();

    // Idle gap after a B read, then a tie
    set_b(1, 4'h0, 32'h20, 32'h0);
    step();
    chk("gap_b_gnt", s_bgnt, 1);
    set_b(0, 4'h0, 32'h0, 32'h0);
    step();
    chk("gap_b_data", s_brd, 32'h22222222);
    step();
    step();
    set_a(1, 4'h0, 32'h10, 32'h0);
    set_b(1, 4'h0, 32'h20, 32'h0);
    step();
    chk("gap_tie_a", s_agnt, 1);

    // Randomized traffic with handshake-respecting requesters and rare resets
    for (int n = 0; n < 600; n++) begin
      if (!a_req || s_agnt)
        set_a($urandom_range(0, 3) != 0, $urandom_range(0, 1) ? 4'h0 : 4'($urandom),
              {26'd0, 4'($urandom), 2'b00}, $urandom);
      if (!b_req || s_bgnt)
        set_b($urandom_range(0, 3) != 0, $urandom_range(0, 1) ? 4'h0 : 4'($urandom),
              {26'd0, 4'($urandom), 2'b00}, $urandom);
      reset = ($urandom_range(0, 59) == 0);
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Two-requester arbiter sharing one single-port data BRAM (1-cycle synchronous read, byte write enables).
- Requester A is the processor core data port; requester B is a DMA/debug loader port.
- Sits between the requesters and the data memory. It grants one access per cycle using round-robin, then returns read data to the requester that issued the read.

Parameters:
- ADDR_W, 32, address width passed through unchanged (byte address)
- DATA_W, 32, data width; must be a multiple of 8
- BE_W, DATA_W/8, byte-enable width

Ports:
- clk  in  1  core clock
- reset  in  1  asynchronous, active-high reset
- a_req  in  1  requester A access request
- a_we  in  BE_W  requester A byte write enables; all zero means read
- a_addr  in  ADDR_W  requester A address
- a_wdata  in  DATA_W  requester A write data
- a_gnt  out  1  requester A access accepted this cycle
- a_rvalid  out  1  requester A read data valid
- a_rdata  out  DATA_W  requester A read data
- b_req, b_we, b_addr, b_wdata, b_gnt, b_rvalid, b_rdata: same as the A ports, for requester B
- mem_en  out  1  BRAM enable
- mem_we  out  BE_W  BRAM byte write enables
- mem_addr  out  ADDR_W  BRAM address
- mem_wdata  out  DATA_W  BRAM write data
- mem_rdata  in  DATA_W  BRAM read data, valid one cycle after an enabled read

Behaviour:
- Handshake:
  - The requester holds req and all request fields stable until it sees gnt=1.
  - The transfer occurs in the cycle where req=gnt=1.
  - The requester may change fields or drop req in the following cycle.
- Grant logic:
  - Grant is combinational from req and the registered priority pointer `last`. At most one gnt is high per cycle.
  - Only a_req: grant A. Only b_req: grant B. Neither: no grant.
  - Both: grant the requester not equal to `last`.
  - `last` updates on every grant to the granted requester; it is unchanged when idle.
- Memory drive (combinational, same cycle as grant):
  - Granted: mem_en=1, and mem_we/mem_addr/mem_wdata come from the granted requester.
  - No grant: mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0.
- Read return pipeline:
  - Registers rd_pend (1 bit) and rd_owner (A/B) capture "granted and we==0" each cycle.
  - The cycle after a granted read, the owner's rvalid=1 and its rdata=mem_rdata.
  - The non-owner's rvalid=0 and rdata=0. Whenever rvalid=0, rdata=0.
  - Writes produce no rvalid; gnt is the write acknowledgement.
- Throughput and latency:
  - One access per cycle, so back-to-back reads give rvalid on consecutive cycles.
  - Read latency is exactly 1 cycle from grant.
  - Alternating grants are fully pipelined: a read by A followed by a read by B on the next cycle returns A's data, then B's data, each to its own port.
- Partial writes: any nonzero we is a write. mem_we is passed through unmodified; byte lanes are not merged.
- Reset (asynchronous assert, synchronous release by upstream sync):
  - rd_pend=0 and last=B, so A wins the first tie.
  - While reset=1: a_gnt=b_gnt=0, mem_en=0, all mem_* outputs 0, all rvalid=0, all rdata=0. Requests are ignored.
- Reset mid-operation: a read granted in the cycle before reset asserts returns no rvalid. The pending read is dropped and not replayed after release.
- Simultaneous events: a request arriving in the same cycle as another requester's rvalid is granted normally; the response path does not block grants.
- Fairness: with both requesters continuously requesting, grants strictly alternate A, B, A, B. No requester waits more than 1 cycle.

Test Plan:
- Reset: hold reset=1 with a_req=b_req=1 -> gnt both 0, mem_en=0, rvalid both 0. Release with both still requesting -> first grant to A, next cycle B.
- A alone writes a_we=4'hF, addr=0x10, data=0xDEADBEEF, then reads 0x10 -> a_gnt high each cycle; a_rvalid exactly 1 cycle after the read grant with a_rdata=0xDEADBEEF; b_rvalid stays 0.
- Contention: both req reads held for 6 cycles, A at 0x10, B at 0x20 (preloaded 0x11111111 and 0x22222222) -> grants A,B,A,B,A,B; rvalid alternates with the correct data per port, never cross-routed.
- Byte write: B writes b_we=4'b0100, data=0x00AB0000 to 0x10, then A reads 0x10 -> 0xDEABBEEF.
- Reset mid-read: A read granted, reset asserted next cycle -> a_rvalid stays 0. After release, `last`=B, so A wins the first tie.
- Idle gap: single B read, then 3 idle cycles, then A and B tie -> A granted, since last=B.
